// File: rtl/dpram_burst_reader_if.sv
// Control, dpram read port and output stream of the burst reader in one bundle.
// master = the reader itself, slave = whoever drives start/ram_q and consumes the stream.
interface dpram_burst_reader_if #(
    parameter int address_width = 10,
    parameter int data_width    = 8
);
    logic                     start;
    logic [address_width-1:0] start_address;
    logic [address_width:0]   length;
    logic                     abort;
    logic                     busy;
    logic                     done;
    logic [address_width-1:0] ram_address;
    logic [data_width-1:0]    ram_q;
    logic [data_width-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    modport master (
        input  start, start_address, length, abort, ram_q, out_ready,
        output busy, done, ram_address, out_data, out_valid, out_last
    );

    modport slave (
        output start, start_address, length, abort, ram_q, out_ready,
        input  busy, done, ram_address, out_data, out_valid, out_last
    );
endinterface

// File: rtl/dpram_burst_reader.sv
// Burst read sequencer: one RAM read per cycle, first word out 3 cycles after start.
// A 3-entry buffer plus a one-read-in-flight credit absorbs out_ready stalls at full rate.
module dpram_burst_reader #(
    parameter int address_width = 10,
    parameter int data_width    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    dpram_burst_reader_if.master  bus
);
    localparam int depth = 3;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [address_width-1:0] ptr;
    logic [address_width:0]   remaining;
    logic                     pending;
    logic                     pending_last;
    logic [data_width-1:0]    fifo_data [depth];
    logic                     fifo_last [depth];
    logic [1:0]               fifo_count;
    logic [1:0]               wr_idx;
    logic                     issue;
    logic                     final_issue;
    logic                     launch;
    logic                     push;
    logic                     pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = (bus.length == '0) ? DONE : FETCH;
                FETCH:   if (final_issue) state_next = DRAIN;
                DRAIN:   if (pop && fifo_last[0]) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Credit counts the read in flight, so issue never looks at out_ready.
    always_comb begin
        issue       = (state == FETCH) && (({1'b0, fifo_count} + {2'b00, pending}) < 3'd3);
        final_issue = issue && (remaining == (address_width+1)'(1));
        launch      = (state == IDLE) && bus.start && !bus.abort;
        push        = pending;
        pop         = (fifo_count != 2'd0) && bus.out_ready;
        wr_idx      = fifo_count - {1'b0, pop};
        bus.busy    = (state == FETCH) || (state == DRAIN);
        bus.done    = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr          <= '0;
            remaining    <= '0;
            pending      <= 1'b0;
            pending_last <= 1'b0;
            fifo_count   <= 2'd0;
            for (int i = 0; i < depth; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else if (bus.abort) begin
            pending      <= 1'b0;
            pending_last <= 1'b0;
            fifo_count   <= 2'd0;
        end else begin
            if (launch) begin
                ptr       <= bus.start_address;
                remaining <= bus.length;
            end else if (issue) begin
                ptr       <= ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            pending      <= issue;
            pending_last <= final_issue;
            // Head sits in slot 0 so out_data is a plain register.
            if (pop) begin
                for (int i = 0; i < depth-1; i++) begin
                    fifo_data[i] <= fifo_data[i+1];
                    fifo_last[i] <= fifo_last[i+1];
                end
            end
            if (push) begin
                fifo_data[wr_idx] <= bus.ram_q;
                fifo_last[wr_idx] <= pending_last;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.ram_address = ptr;
    assign bus.out_data    = fifo_data[0];
    assign bus.out_valid   = (fifo_count != 2'd0);
    assign bus.out_last    = (fifo_count != 2'd0) && fifo_last[0];
endmodule

// File: tb/tb_dpram_burst_reader.sv
// Directed bench for dpram_burst_reader with a 16-word registered RAM model.
module tb_dpram_burst_reader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dpram_burst_reader_if #(.address_width(4), .data_width(8)) bus ();

    dpram_burst_reader #(.address_width(4), .data_width(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [16];
    always @(posedge clock) bus.ram_q <= mem[bus.ram_address];

    int n_vec  = 0;
    int n_miss = 0;
    int overflow_events = 0;

    always @(negedge clock)
        if (!reset && dut.fifo_count == 2'd3 && dut.pending && !(bus.out_valid && bus.out_ready))
            overflow_events++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] got_d [64];
    logic       got_l [64];
    int         got_c [64];
    logic [3:0] addr_log [64];
    logic       valid_log [64];
    logic       busy_log [64];
    int got_n, done_c, done_count;
    bit valid_seen, busy_seen;

    task automatic run_burst(input logic [3:0] addr, input logic [4:0] len, input logic [3:0] rdy_pat,
                             input int abort_c, input int restart_c, input int max_c);
        bit stall_prev;
        logic [7:0] held_d;
        got_n = 0; done_c = -1; done_count = 0; valid_seen = 0; busy_seen = 0;
        stall_prev = 0; held_d = '0;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.start_address = addr; bus.length = len; bus.out_ready = rdy_pat[0];
        for (int c = 1; c <= max_c; c++) begin
            @(posedge clock); #1;
            bus.start = 1'b0; bus.abort = 1'b0;
            bus.out_ready = rdy_pat[c % 4];
            if (c == abort_c) begin bus.abort = 1'b1; bus.out_ready = 1'b0; end
            if (c == restart_c) begin bus.start = 1'b1; bus.start_address = addr + 4'd5; bus.length = 5'd2; end
            @(negedge clock);
            addr_log[c]  = bus.ram_address;
            valid_log[c] = bus.out_valid;
            busy_log[c]  = bus.busy;
            if (bus.out_valid) valid_seen = 1;
            if (bus.busy) busy_seen = 1;
            if (bus.done) begin done_count++; if (done_c < 0) done_c = c; end
            if (stall_prev && (c - 1) != abort_c)
                check_val($sformatf("hold_data_c%0d", c), {24'd0, bus.out_data}, {24'd0, held_d});
            if (bus.out_valid && bus.out_ready) begin
                got_d[got_n] = bus.out_data; got_l[got_n] = bus.out_last; got_c[got_n] = c;
                got_n++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
        end
    endtask

    task automatic check_words(input string t, input int n, input logic [7:0] first_d,
                               input logic [3:0] addr_step_base, input int first_cycle);
        check_val({t, "_count"}, got_n, n);
        for (int i = 0; i < n && i < got_n; i++) begin
            logic [7:0] exp_d;
            exp_d = 8'h10 + {4'h0, addr_step_base + i[3:0]};
            check_val($sformatf("%s_data%0d", t, i), {24'd0, got_d[i]}, {24'd0, exp_d});
            check_val($sformatf("%s_last%0d", t, i), {31'd0, got_l[i]}, {31'd0, (i == n-1)});
            if (first_cycle > 0)
                check_val($sformatf("%s_cyc%0d", t, i), got_c[i], first_cycle + i);
        end
        if (first_d != 8'h00) check_val({t, "_first"}, {24'd0, got_d[0]}, {24'd0, first_d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        bus.start = 0; bus.start_address = '0; bus.length = '0; bus.abort = 0; bus.out_ready = 0;
        #2;
        check_val("rst_busy",  {31'd0, bus.busy}, 0);
        check_val("rst_done",  {31'd0, bus.done}, 0);
        check_val("rst_valid", {31'd0, bus.out_valid}, 0);
        check_val("rst_last",  {31'd0, bus.out_last}, 0);
        check_val("rst_data",  {24'd0, bus.out_data}, 0);
        check_val("rst_addr",  {28'd0, bus.ram_address}, 0);
        @(posedge clock); #1 reset = 1'b0;

        // 1: basic latency and framing
        run_burst(4'd2, 5'd4, 4'b1111, -1, -1, 9);
        check_val("t1_addr_c1", {28'd0, addr_log[1]}, 2);
        check_words("t1", 4, 8'h12, 4'd2, 3);
        check_val("t1_done_cyc", done_c, 7);
        check_val("t1_done_cnt", done_count, 1);

        // 2: address wrap
        run_burst(4'd14, 5'd4, 4'b1111, -1, -1, 9);
        check_val("t2_addr_c1", {28'd0, addr_log[1]}, 14);
        check_val("t2_addr_c2", {28'd0, addr_log[2]}, 15);
        check_val("t2_addr_c3", {28'd0, addr_log[3]}, 0);
        check_val("t2_addr_c4", {28'd0, addr_log[4]}, 1);
        check_words("t2", 4, 8'h1e, 4'd14, 3);

        // 3: zero-length burst
        run_burst(4'd4, 5'd0, 4'b1111, -1, -1, 5);
        check_val("t3_done_cyc", done_c, 1);
        check_val("t3_done_cnt", done_count, 1);
        check_val("t3_valid",    {31'd0, valid_seen}, 0);
        check_val("t3_busy",     {31'd0, busy_seen}, 0);

        // 4: backpressure with ready 1,0,0,1
        run_burst(4'd5, 5'd8, 4'b1001, -1, -1, 60);
        check_words("t4", 8, 8'h15, 4'd5, 0);
        check_val("t4_done_cnt", done_count, 1);

        // 5: abort after two transfers, then a clean restart
        run_burst(4'd0, 5'd10, 4'b1111, 5, -1, 12);
        check_val("t5_count", got_n, 2);
        check_val("t5_d0", {24'd0, got_d[0]}, 8'h10);
        check_val("t5_d1", {24'd0, got_d[1]}, 8'h11);
        check_val("t5_valid_c6", {31'd0, valid_log[6]}, 0);
        check_val("t5_busy_c6",  {31'd0, busy_log[6]}, 0);
        check_val("t5_done_cnt", done_count, 0);
        begin
            bit late_valid;
            late_valid = 0;
            for (int c = 6; c <= 12; c++) if (valid_log[c]) late_valid = 1;
            check_val("t5_valid_after", {31'd0, late_valid}, 0);
        end
        run_burst(4'd9, 5'd3, 4'b1111, -1, -1, 8);
        check_words("t5r", 3, 8'h19, 4'd9, 3);
        check_val("t5r_done_cyc", done_c, 6);

        // 6a: start during an active burst is ignored
        run_burst(4'd3, 5'd6, 4'b1111, -1, 2, 11);
        check_words("t6a", 6, 8'h13, 4'd3, 3);
        check_val("t6a_addr_c3", {28'd0, addr_log[3]}, 5);
        check_val("t6a_done_cyc", done_c, 9);
        check_val("t6a_done_cnt", done_count, 1);

        // 6b: asynchronous reset mid-burst
        @(posedge clock); #1;
        bus.start = 1'b1; bus.start_address = 4'd7; bus.length = 5'd8; bus.out_ready = 1'b1;
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("t6b_busy_pre",  {31'd0, bus.busy}, 1);
        check_val("t6b_valid_pre", {31'd0, bus.out_valid}, 1);
        #1 reset = 1'b1;
        #1;
        check_val("t6b_busy",  {31'd0, bus.busy}, 0);
        check_val("t6b_done",  {31'd0, bus.done}, 0);
        check_val("t6b_valid", {31'd0, bus.out_valid}, 0);
        check_val("t6b_last",  {31'd0, bus.out_last}, 0);
        check_val("t6b_data",  {24'd0, bus.out_data}, 0);
        check_val("t6b_addr",  {28'd0, bus.ram_address}, 0);
        @(posedge clock); #1 reset = 1'b0;
        run_burst(4'd1, 5'd2, 4'b1111, -1, -1, 7);
        check_words("t6c", 2, 8'h11, 4'd1, 3);
        check_val("t6c_done_cyc", done_c, 5);

        check_val("no_overflow", overflow_events, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
